// File: rtl/ddr_block_fetcher.sv
// Fetches 8x8 blocks of 32-bit words from DDR3, one single-beat read at a time, and
// presents each assembled block with its block number on a valid/ready handshake.
module ddr_block_fetcher #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 128,
    parameter int BLOCK_WIDTH = 8,
    parameter int BLKNUM_W    = 12
) (
    input  logic                                  iCLK,
    input  logic                                  iRST_N,
    input  logic                                  start,
    input  logic [ADDR_W-1:0]                     start_address,
    input  logic [BLKNUM_W-1:0]                   first_block_num,
    input  logic [BLKNUM_W:0]                     num_blocks,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  blk_valid,
    input  logic                                  blk_ready,
    output logic [BLOCK_WIDTH*BLOCK_WIDTH*32-1:0] block,
    output logic [BLKNUM_W-1:0]                   block_num,
    input  logic                                  local_init_done,
    output logic [ADDR_W-1:0]                     avl_address,
    output logic                                  avl_read,
    output logic                                  avl_burstbegin,
    input  logic                                  avl_wait_request_n,
    input  logic [DATA_W-1:0]                     avl_readdata,
    input  logic                                  avl_readdatavalid
);
    localparam int BLOCK_BITS = BLOCK_WIDTH * BLOCK_WIDTH * 32;
    localparam int BEATS      = BLOCK_BITS / DATA_W;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BLKNUM_W:0]   ONE_BLK   = (BLKNUM_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [BEAT_W-1:0] beat;
    logic [BLKNUM_W:0] blk_cnt;
    logic [BLKNUM_W:0] run_blocks;
    logic              last_blk;

    assign last_blk = (blk_cnt == run_blocks - ONE_BLK);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b1;
        done           = 1'b0;
        blk_valid      = 1'b0;
        avl_read       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && local_init_done) begin
                    state_nxt = (num_blocks == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                avl_read = 1'b1;
                if (avl_wait_request_n) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (avl_readdatavalid) begin
                    state_nxt = (beat == LAST_BEAT) ? S_PRESENT : S_READ;
                end
            end
            S_PRESENT: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    state_nxt = last_blk ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
        avl_burstbegin = avl_read;
    end

    // Address, beat and block counters advance only on completed beats and block transfers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            avl_address <= '0;
            block       <= '0;
            block_num   <= '0;
            beat        <= '0;
            blk_cnt     <= '0;
            run_blocks  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && local_init_done) begin
                        avl_address <= start_address;
                        block_num   <= first_block_num;
                        run_blocks  <= num_blocks;
                        blk_cnt     <= '0;
                        beat        <= '0;
                    end
                end
                S_WAIT: begin
                    if (avl_readdatavalid) begin
                        block[int'(beat)*DATA_W +: DATA_W] <= avl_readdata;
                        if (beat == LAST_BEAT) begin
                            beat <= '0;
                        end else begin
                            beat        <= beat + BEAT_W'(1);
                            avl_address <= avl_address + ADDR_W'(1);
                        end
                    end
                end
                S_PRESENT: begin
                    if (blk_ready) begin
                        block_num <= block_num + BLKNUM_W'(1);
                        if (!last_blk) begin
                            blk_cnt     <= blk_cnt + ONE_BLK;
                            avl_address <= avl_address + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_block_fetcher.sv
// Randomized bench for ddr_block_fetcher: DDR3 responder with random wait-request and
// read latency, a stalling block sink, and a queue-based model of reads and blocks.
module tb_ddr_block_fetcher;
    localparam int ADDR_W   = 26;
    localparam int DATA_W   = 128;
    localparam int BW       = 8;
    localparam int BLKNUM_W = 12;
    localparam int BB       = BW * BW * 32;

    logic                iCLK = 1'b0;
    logic                iRST_N = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   start_address = '0;
    logic [BLKNUM_W-1:0] first_block_num = '0;
    logic [BLKNUM_W:0]   num_blocks = '0;
    logic                busy, done, blk_valid;
    logic                blk_ready = 1'b0;
    logic [BB-1:0]       block;
    logic [BLKNUM_W-1:0] block_num;
    logic                local_init_done = 1'b1;
    logic [ADDR_W-1:0]   avl_address;
    logic                avl_read, avl_burstbegin;
    logic                avl_wait_request_n = 1'b0;
    logic [DATA_W-1:0]   avl_readdata = '0;
    logic                avl_readdatavalid = 1'b0;

    always #5 iCLK = ~iCLK;

    ddr_block_fetcher #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WIDTH(BW), .BLKNUM_W(BLKNUM_W)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .start(start), .start_address(start_address),
        .first_block_num(first_block_num), .num_blocks(num_blocks), .busy(busy),
        .done(done), .blk_valid(blk_valid), .blk_ready(blk_ready), .block(block),
        .block_num(block_num), .local_init_done(local_init_done),
        .avl_address(avl_address), .avl_read(avl_read), .avl_burstbegin(avl_burstbegin),
        .avl_wait_request_n(avl_wait_request_n), .avl_readdata(avl_readdata),
        .avl_readdatavalid(avl_readdatavalid)
    );

    int nvec = 0;
    int nmis = 0;

    logic [ADDR_W-1:0]   exp_addr[$];
    logic [BB-1:0]       exp_blk[$];
    logic [BLKNUM_W-1:0] exp_num[$];

    logic [31:0] salt = 32'h0;
    int wr_max = 0;
    bit wr_fixed = 1'b0;
    int lat_max = 1;
    int rdy_stall = 0;
    bit rdy_rand = 1'b0;
    bit spur_en = 1'b1;
    int done_cnt = 0;
    int acc_cnt = 0;
    int rd_cyc = 0;

    // Memory contents: 32-bit word w of DDR beat address a
    function automatic logic [31:0] memword(logic [ADDR_W-1:0] a, int w);
        return ({4'b0, a, 2'b00} + 32'(w)) ^ salt;
    endfunction

    function automatic logic [DATA_W-1:0] membeat(logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        for (int w = 0; w < DATA_W/32; w++) d[32*w +: 32] = memword(a, w);
        return d;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_blk(string name, logic [BB-1:0] act, logic [BB-1:0] exp);
        nvec++;
        if (act !== exp) begin
            int i;
            i = 0;
            while (i < 63 && act[32*i +: 32] === exp[32*i +: 32]) i++;
            nmis++;
            $display("FAIL %s: word %0d got 0x%0h, expected 0x%0h (t=%0t)",
                     name, i, act[32*i +: 32], exp[32*i +: 32], $time);
        end
    endtask

    task automatic flush();
        exp_addr.delete();
        exp_blk.delete();
        exp_num.delete();
    endtask

    // Reference model: block b reads start+16b.., word i comes from beat i/4, lane i%4
    task automatic build(logic [ADDR_W-1:0] a, logic [BLKNUM_W-1:0] f, logic [BLKNUM_W:0] n);
        for (int b = 0; b < int'(n); b++) begin
            logic [BB-1:0] blk;
            for (int j = 0; j < 16; j++) exp_addr.push_back(a + ADDR_W'(16*b + j));
            for (int i = 0; i < 64; i++) blk[32*i +: 32] = memword(a + ADDR_W'(16*b + i/4), i % 4);
            exp_blk.push_back(blk);
            exp_num.push_back(f + BLKNUM_W'(b));
        end
    endtask

    task automatic pulse(logic [ADDR_W-1:0] a, logic [BLKNUM_W-1:0] f, logic [BLKNUM_W:0] n);
        @(negedge iCLK);
        start = 1'b1;
        start_address = a;
        first_block_num = f;
        num_blocks = n;
        @(negedge iCLK);
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        if (!done) begin
            nvec++;
            nmis++;
            $display("FAIL done_timeout: no done within %0d cycles, required a done pulse", budget);
        end
    endtask

    task automatic run(logic [ADDR_W-1:0] a, logic [BLKNUM_W-1:0] f, logic [BLKNUM_W:0] n,
                       int budget, bit glitch);
        int d0;
        d0 = done_cnt;
        build(a, f, n);
        pulse(a, f, n);
        chk("busy_after_start", 32'(busy), 1);
        if (glitch) begin
            repeat (20) @(negedge iCLK);
            start = 1'b1;
            start_address = ~a;
            first_block_num = ~f;
            num_blocks = 13'd3;
            local_init_done = 1'b0;
            @(negedge iCLK);
            local_init_done = 1'b1;
            repeat (2) @(negedge iCLK);
            start = 1'b0;
        end
        wait_done(budget);
        repeat (3) @(negedge iCLK);
        chk("done_pulses", 32'(done_cnt - d0), 1);
        chk("busy_idle", 32'(busy), 0);
        chk("reads_left", 32'(exp_addr.size()), 0);
        chk("blocks_left", 32'(exp_blk.size()), 0);
        flush();
    endtask

    // DDR3 responder, block sink and per-cycle comparison against the model
    int ws_cnt = -1;
    int rdy_cnt = -1;
    int pend_cnt = 0;
    bit pend = 1'b0;
    bit hold_rd = 1'b0;
    bit hold_blk = 1'b0;
    logic [ADDR_W-1:0]   pend_addr = '0;
    logic [ADDR_W-1:0]   hold_addr = '0;
    logic [BB-1:0]       hold_block = '0;
    logic [BLKNUM_W-1:0] hold_num = '0;

    always @(negedge iCLK) begin
        if (!iRST_N) begin
            pend = 1'b0;
            ws_cnt = -1;
            rdy_cnt = -1;
            hold_rd = 1'b0;
            hold_blk = 1'b0;
            avl_wait_request_n = 1'b0;
            avl_readdatavalid = 1'b0;
            blk_ready = 1'b0;
        end else begin
            if (hold_rd) begin
                chk("rd_hold_read", 32'(avl_read), 1);
                chk("rd_hold_addr", 32'(avl_address), 32'(hold_addr));
            end
            if (hold_blk) begin
                chk("blk_hold_valid", 32'(blk_valid), 1);
                chk_blk("blk_hold_data", block, hold_block);
                chk("blk_hold_num", 32'(block_num), 32'(hold_num));
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 32'(busy), 1);
            end
            if (avl_read) rd_cyc++;

            avl_readdatavalid = 1'b0;
            avl_readdata = {$urandom, $urandom, $urandom, $urandom};
            if (pend) begin
                if (pend_cnt == 0) begin
                    avl_readdatavalid = 1'b1;
                    avl_readdata = membeat(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end else if (!avl_read && spur_en) begin
                avl_readdatavalid = ($urandom_range(0, 3) == 0);
            end

            hold_rd = 1'b0;
            if (avl_read) begin
                if (ws_cnt < 0) ws_cnt = wr_fixed ? wr_max : int'($urandom_range(0, wr_max));
                if (ws_cnt == 0) begin
                    avl_wait_request_n = 1'b1;
                    ws_cnt = -1;
                    acc_cnt++;
                    chk("burstbegin", 32'(avl_burstbegin), 1);
                    chk("one_outstanding", 32'(pend), 0);
                    if (exp_addr.size() == 0) begin
                        nvec++;
                        nmis++;
                        $display("FAIL read_addr: unexpected read at 0x%0h, required no read", avl_address);
                    end else begin
                        chk("read_addr", 32'(avl_address), 32'(exp_addr.pop_front()));
                    end
                    pend = 1'b1;
                    pend_addr = avl_address;
                    pend_cnt = int'($urandom_range(1, lat_max)) - 1;
                end else begin
                    avl_wait_request_n = 1'b0;
                    ws_cnt--;
                    hold_rd = 1'b1;
                    hold_addr = avl_address;
                end
            end else begin
                avl_wait_request_n = 1'($urandom_range(0, 1));
            end

            hold_blk = 1'b0;
            if (blk_valid) begin
                if (rdy_cnt < 0) rdy_cnt = rdy_rand ? int'($urandom_range(0, rdy_stall)) : rdy_stall;
                if (rdy_cnt == 0) begin
                    blk_ready = 1'b1;
                    rdy_cnt = -1;
                    if (exp_blk.size() == 0) begin
                        nvec++;
                        nmis++;
                        $display("FAIL block_data: unexpected block num 0x%0h, required none", block_num);
                    end else begin
                        chk_blk("block_data", block, exp_blk.pop_front());
                        chk("block_num", 32'(block_num), 32'(exp_num.pop_front()));
                    end
                end else begin
                    blk_ready = 1'b0;
                    rdy_cnt--;
                    hold_blk = 1'b1;
                    hold_block = block;
                    hold_num = block_num;
                end
            end else begin
                blk_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, a0, k;
        logic [BB-1:0] tblk;

        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_blk_valid", 32'(blk_valid), 0);
        chk("rst_avl_read", 32'(avl_read), 0);
        chk("rst_avl_address", 32'(avl_address), 0);
        chk("rst_block_num", 32'(block_num), 0);
        chk_blk("rst_block", block, '0);
        @(negedge iCLK);
        @(negedge iCLK);
        iRST_N = 1'b1;

        // Hand-computed pins on the model for the first scenario
        salt = 32'h0;
        build(26'h100, 12'd5, 13'd1);
        chk("pin_addr0", 32'(exp_addr[0]), 32'h100);
        chk("pin_addr15", 32'(exp_addr[15]), 32'h10F);
        tblk = exp_blk[0];
        chk("pin_word0", tblk[31:0], 32'h400);
        chk("pin_word5", tblk[191:160], 32'h405);
        chk("pin_word63", tblk[2047:2016], 32'h43F);
        chk("pin_num", 32'(exp_num[0]), 32'd5);
        flush();

        // Single block, no stalls
        wr_fixed = 1'b0; wr_max = 0; lat_max = 1; rdy_rand = 1'b0; rdy_stall = 0;
        run(26'h100, 12'd5, 13'd1, 3000, 1'b0);

        // Three blocks with a stalled sink
        rdy_stall = 10;
        run(26'h100, 12'd5, 13'd3, 3000, 1'b0);

        // Wait-request stalls, random latency, ignored start mid-run
        wr_fixed = 1'b1; wr_max = 4; lat_max = 8; rdy_stall = 0; salt = 32'h5a5a1234;
        run(26'h1234, 12'd77, 13'd2, 3000, 1'b1);
        wr_fixed = 1'b0; wr_max = 1; lat_max = 3;

        // Zero blocks, then start without calibration
        d0 = done_cnt;
        r0 = rd_cyc;
        pulse(26'h40, 12'd3, 13'd0);
        chk("zero_busy", 32'(busy), 1);
        chk("zero_done", 32'(done), 1);
        @(negedge iCLK);
        chk("zero_busy_end", 32'(busy), 0);
        chk("zero_done_end", 32'(done), 0);
        repeat (2) @(negedge iCLK);
        chk("zero_reads", 32'(rd_cyc - r0), 0);
        chk("zero_done_cnt", 32'(done_cnt - d0), 1);
        local_init_done = 1'b0;
        start = 1'b1;
        start_address = 26'h80;
        num_blocks = 13'd1;
        repeat (3) begin
            @(negedge iCLK);
            chk("nocal_busy", 32'(busy), 0);
        end
        start = 1'b0;
        local_init_done = 1'b1;
        @(negedge iCLK);
        chk("nocal_reads", 32'(rd_cyc - r0), 0);

        // Reset while waiting for beat 7
        salt = 32'hc0ffee00; lat_max = 4;
        a0 = acc_cnt;
        build(26'h200, 12'd1, 13'd1);
        pulse(26'h200, 12'd1, 13'd1);
        k = 0;
        while (acc_cnt - a0 < 8 && k < 1000) begin @(negedge iCLK); k++; end
        while (avl_read && k < 1000) begin @(negedge iCLK); k++; end
        chk("rst_wait_reached", 32'(k < 1000), 1);
        #2 iRST_N = 1'b0;
        #1;
        chk("rstw_avl_read", 32'(avl_read), 0);
        chk("rstw_blk_valid", 32'(blk_valid), 0);
        chk("rstw_busy", 32'(busy), 0);
        @(negedge iCLK);
        @(negedge iCLK);
        flush();
        iRST_N = 1'b1;

        // Reset while a block is stalled on the handshake
        rdy_stall = 40;
        build(26'h280, 12'd2, 13'd1);
        pulse(26'h280, 12'd2, 13'd1);
        k = 0;
        while (!blk_valid && k < 2000) begin @(negedge iCLK); k++; end
        chk("rst_present_reached", 32'(blk_valid), 1);
        #2 iRST_N = 1'b0;
        #1;
        chk("rstp_blk_valid", 32'(blk_valid), 0);
        chk("rstp_busy", 32'(busy), 0);
        chk("rstp_block_num", 32'(block_num), 0);
        chk("rstp_avl_address", 32'(avl_address), 0);
        chk_blk("rstp_block", block, '0);
        @(negedge iCLK);
        @(negedge iCLK);
        flush();
        iRST_N = 1'b1;
        rdy_stall = 0;
        run(26'h300, 12'd9, 13'd1, 3000, 1'b0);

        // Address and block-number wrap
        build(26'h3FFFFF8, 12'd0, 13'd1);
        chk("pin_wrap_a7", 32'(exp_addr[7]), 32'h3FFFFFF);
        chk("pin_wrap_a8", 32'(exp_addr[8]), 32'h0);
        chk("pin_wrap_a15", 32'(exp_addr[15]), 32'h7);
        flush();
        run(26'h3FFFFF8, 12'd0, 13'd1, 3000, 1'b0);
        build(26'h3FFFFF0, 12'hFFF, 13'd2);
        chk("pin_num_wrap0", 32'(exp_num[0]), 32'hFFF);
        chk("pin_num_wrap1", 32'(exp_num[1]), 32'h0);
        flush();
        run(26'h3FFFFF0, 12'hFFF, 13'd2, 3000, 1'b0);

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            salt = $urandom;
            wr_max = int'($urandom_range(0, 3));
            lat_max = int'($urandom_range(1, 8));
            rdy_rand = 1'b1;
            rdy_stall = int'($urandom_range(0, 6));
            run(ADDR_W'($urandom), BLKNUM_W'($urandom), (BLKNUM_W+1)'($urandom_range(1, 2)),
                3000, r == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
